rf_read_port_arbiter: RTL and testbench

- Shares the single 32-input, 32-bit register read mux (mux_32_32) among NUM_REQ requesters, such as decode, debug dump and a trap-save sequencer.
- Round-robin arbitration with a valid/ready handshake.
- Drives the mux select from a register, captures the mux output one cycle later, and returns the data tagged with the requester id.
- Sits between the requesters and the mux instance in the register-file read path.

---
 rtl/rf_read_port_arbiter.sv | 105 ++++++++++
 tb/tb_rf_read_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_port_arbiter.sv
// rf_read_port_arbiter: round-robin sharing of the single 32x32 register read mux.
// Stage 1 registers the mux select and request tag; stage 2 captures mux_out
// one cycle later and presents it, tagged with the requester id, on a
// valid/ready response port. Two reads can be outstanding during a stall.
module rf_read_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*5-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [4:0]           mux_sel,
    input  logic [31:0]          mux_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data
);

    logic            s1_v;
    logic [ID_W-1:0] s1_id;
    logic            s1_zero;
    logic [ID_W-1:0] last_grant;

    logic            adv1;
    logic            adv2;
    logic            found;
    logic            accept;
    logic [ID_W-1:0] win;
    logic [4:0]      win_addr;
    int              best;

    // Stage 2 can take new data when empty or being drained; stage 1 likewise.
    assign adv2   = !rsp_valid || rsp_ready;
    assign adv1   = !s1_v || adv2;
    assign found  = (best < NUM_REQ);
    assign accept = found && adv1;

    // Pick the valid requester closest after last_grant in circular order.
    always_comb begin
        best = NUM_REQ;
        win  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] &&
                (((j + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ) < best)) begin
                best = (j + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
                win  = ID_W'(j);
            end
        end
    end

    // Select the winner's address and drive the one-hot grant, held off during reset.
    always_comb begin
        win_addr  = '0;
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win == ID_W'(j)) begin
                win_addr     = req_addr[j*5 +: 5];
                req_ready[j] = found && adv1 && !rst;
            end
        end
    end

    // Stage 1: latch the granted address into the mux select and remember who asked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_sel    <= '0;
            s1_v       <= 1'b0;
            s1_id      <= '0;
            s1_zero    <= 1'b0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (adv1) begin
            if (accept) begin
                mux_sel    <= win_addr;
                s1_v       <= 1'b1;
                s1_id      <= win;
                s1_zero    <= (ZERO_R0 != 0) && (win_addr == 5'd0);
                last_grant <= win;
            end else begin
                s1_v <= 1'b0;
            end
        end
    end

    // Stage 2: capture the mux output for the read sitting in stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (adv2) begin
            if (s1_v) begin
                rsp_valid <= 1'b1;
                rsp_id    <= s1_id;
                rsp_data  <= s1_zero ? 32'h0 : mux_out;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Testbench for rf_read_port_arbiter: directed vector table, hand-written
// backpressure / R0 / mid-operation reset sequences and a randomized phase,
// all checked against a queue-based reference model of the read port.
module tb_rf_read_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic        rsp_ready;

    logic [3:0]  req_ready, req_ready0;
    logic [4:0]  mux_sel, mux_sel0;
    logic [31:0] mux_out, mux_out0;
    logic        rsp_valid, rsp_valid0;
    logic [1:0]  rsp_id, rsp_id0;
    logic [31:0] rsp_data, rsp_data0;

    logic [31:0] mem [32];

    assign mux_out  = mem[mux_sel];
    assign mux_out0 = mem[mux_sel0];

    rf_read_port_arbiter #(.NUM_REQ(4), .ID_W(2), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .mux_sel(mux_sel), .mux_out(mux_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data)
    );

    rf_read_port_arbiter #(.NUM_REQ(4), .ID_W(2), .ZERO_R0(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready0), .mux_sel(mux_sel0), .mux_out(mux_out0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_id(rsp_id0),
        .rsp_data(rsp_data0)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] d1;
        logic [31:0] d0;
        int          acc;
    } ent_t;

    typedef struct {
        logic [3:0]  valid;
        logic [19:0] addr;
        logic        rr;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [31:0] exp_data;
        logic [4:0]  exp_sel;
    } vec_t;

    ent_t        q[$];
    int          m_last;
    int          m_n;
    logic [4:0]  m_sel;
    logic        m_rv;
    int          m_id;
    logic [31:0] m_d1;
    logic [31:0] m_d0;
    logic [3:0]  got_ready;
    int          total = 0;
    int          bad = 0;
    vec_t        tbl [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [19:0] a, input logic r);
        req_valid = v;
        req_addr  = a;
        rsp_ready = r;
    endtask

    task automatic modelReset();
        q.delete();
        m_last = 3;
        m_n    = 0;
        m_sel  = '0;
        m_rv   = 1'b0;
        m_id   = 0;
        m_d1   = '0;
        m_d0   = '0;
    endtask

    // One clock cycle: check the grant before the edge, advance the model, check outputs after.
    task automatic tick();
        int          w;
        bit          vis, pop, can;
        logic [3:0]  exp_ready;
        logic [4:0]  a;
        ent_t        e;
        #1;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (w < 0 && req_valid[idx]) w = idx;
        end
        vis = (q.size() > 0) && (q[0].acc < m_n);
        pop = vis && rsp_ready;
        can = (q.size() < 2) || rsp_ready;
        exp_ready = '0;
        if (w >= 0 && can) exp_ready[w] = 1'b1;
        got_ready = req_ready;
        checkOutput("req_ready", req_ready, exp_ready);
        @(posedge clk);
        m_n++;
        if (pop) void'(q.pop_front());
        if (w >= 0 && can) begin
            a    = req_addr[w*5 +: 5];
            e.id = w;
            e.d1 = (a == 5'd0) ? 32'h0 : mem[a];
            e.d0 = mem[a];
            e.acc = m_n;
            q.push_back(e);
            m_last = w;
            m_sel  = a;
        end
        m_rv = (q.size() > 0) && (q[0].acc < m_n);
        if (m_rv) begin
            m_id = q[0].id;
            m_d1 = q[0].d1;
            m_d0 = q[0].d0;
        end
        #1;
        checkOutput("rsp_valid", rsp_valid, m_rv);
        checkOutput("mux_sel", mux_sel, m_sel);
        checkOutput("rsp_id", rsp_id, m_id[1:0]);
        checkOutput("rsp_data", rsp_data, m_d1);
        checkOutput("rsp_data_nozero", rsp_data0, m_d0);
    endtask

    // Main test sequence.
    initial begin
        int stall_acc;
        for (int k = 0; k < 32; k++) mem[k] = 32'h100 + k;

        tbl[0]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0,   5'd20};
        tbl[1]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h114, 5'd21};
        tbl[2]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h115, 5'd22};
        tbl[3]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h116, 5'd23};
        tbl[4]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h117, 5'd20};
        tbl[5]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h114, 5'd21};
        tbl[6]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h115, 5'd22};
        tbl[7]  = '{4'hF, 20'hBDAB4, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h116, 5'd23};
        tbl[8]  = '{4'h0, 20'hBDAB4, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h117, 5'd23};
        tbl[9]  = '{4'h0, 20'h00000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'h117, 5'd23};
        tbl[10] = '{4'h2, 20'h000E0, 1'b1, 4'b0010, 1'b0, 2'd3, 32'h117, 5'd7};
        tbl[11] = '{4'h0, 20'h00000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h107, 5'd7};
        tbl[12] = '{4'h0, 20'h00000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h107, 5'd7};

        rst = 1'b1;
        applyStimulus(4'hF, 20'h0, 1'b1);
        modelReset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_req_ready", req_ready, 4'b0);
            checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
            checkOutput("reset_rsp_data", rsp_data, 32'h0);
            checkOutput("reset_rsp_id", rsp_id, 2'd0);
            checkOutput("reset_mux_sel", mux_sel, 5'd0);
        end
        rst = 1'b0;
        applyStimulus(4'h0, 20'h0, 1'b1);
        for (int c = 0; c < 10; c++) tick();

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].addr, tbl[i].rr);
            tick();
            checkOutput($sformatf("vec%0d_ready", i), got_ready, tbl[i].exp_ready);
            checkOutput($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].exp_rv);
            checkOutput($sformatf("vec%0d_rsp_id", i), rsp_id, tbl[i].exp_id);
            checkOutput($sformatf("vec%0d_rsp_data", i), rsp_data, tbl[i].exp_data);
            checkOutput($sformatf("vec%0d_mux_sel", i), mux_sel, tbl[i].exp_sel);
        end

        $display("[TB] backpressure");
        stall_acc = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'hF, 20'($urandom), 1'b0);
            tick();
            stall_acc += $countones(got_ready);
        end
        checkOutput("stall_accepts", stall_acc, 2);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'hF, 20'($urandom), 1'b1);
            tick();
        end
        applyStimulus(4'h0, 20'h0, 1'b1);
        for (int c = 0; c < 3; c++) tick();

        $display("[TB] r0 zero");
        mem[0] = 32'hDEADBEEF;
        applyStimulus(4'b0100, 20'h0, 1'b1);
        tick();
        applyStimulus(4'h0, 20'h0, 1'b1);
        tick();
        checkOutput("r0_valid", rsp_valid, 1'b1);
        checkOutput("r0_zero", rsp_data, 32'h0);
        checkOutput("r0_nozero", rsp_data0, 32'hDEADBEEF);
        tick();
        mem[0] = 32'h100;

        $display("[TB] random");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), 20'($urandom), ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("[TB] reset mid-operation");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'hF, 20'($urandom), 1'b0);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("midrst_mux_sel", mux_sel, 5'd0);
        checkOutput("midrst_req_ready", req_ready, 4'b0);
        checkOutput("midrst_rsp_data", rsp_data, 32'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'hF, 20'($urandom), 1'b1);
        tick();
        checkOutput("midrst_first_grant", got_ready, 4'b0001);
        applyStimulus(4'h0, 20'h0, 1'b1);
        for (int c = 0; c < 4; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
